// File: rtl/s_axi_lite_regs_pkg.sv
// Shared constants and helpers for the AXI4-Lite slave register file.
// The response codes are also used by the bus master's error decode.
package s_axi_lite_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Ceiling log2. A value of 1 yields 0, so a one-byte data width needs no address LSBs.
    function automatic int clogb2(input int value);
        int result;
        int one;
        result = 0;
        one    = 1;
        for (int i = 0; i < 31; i++) begin
            if ((one << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// NREG x DWIDTH register array with a byte-enable write port and a registered read port.
// The read port can be told to return zero, which is used for out-of-window reads.
module axi_lite_regfile
    import s_axi_lite_regs_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREG   = 16,
    parameter int IDXW   = clogb2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDXW-1:0]        wr_idx,
    input  logic [DWIDTH-1:0]      wr_data,
    input  logic [DWIDTH/8-1:0]    wr_strb,
    input  logic                   rd_en,
    input  logic [IDXW-1:0]        rd_idx,
    input  logic                   rd_zero,
    output logic [DWIDTH-1:0]      rd_data,
    output logic [NREG*DWIDTH-1:0] regs
);

    localparam int NBYTES = DWIDTH / 8;

    logic [DWIDTH-1:0] mem_r [NREG];
    logic [DWIDTH-1:0] rd_data_r;

    // Register array: clear on reset, byte-lane write otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                mem_r[k] <= {DWIDTH{1'b0}};
            end
        end else if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_strb[i]) begin
                    mem_r[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read port: samples the pre-write contents when a write lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DWIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_zero ? {DWIDTH{1'b0}} : mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs[k*DWIDTH +: DWIDTH] = mem_r[k];
    end

endmodule

// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite slave terminating single-beat reads/writes into a byte-strobed register bank.
// Holds the AW/W slots, address decode, response flops and handshakes.
module s_axi_lite_regs
    import s_axi_lite_regs_pkg::*;
#(
    parameter int                DWIDTH = 32,
    parameter int                NREG   = 16,
    parameter logic [DWIDTH-1:0] BASE   = {DWIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DWIDTH-1:0]         awaddr,
    input  logic [2:0]                awprot,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DWIDTH-1:0]         wdata,
    input  logic [DWIDTH/8-1:0]       wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [DWIDTH-1:0]         araddr,
    input  logic [2:0]                arprot,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DWIDTH-1:0]         rdata,
    output logic [1:0]                rresp,
    output logic [NREG*DWIDTH-1:0]    regs,
    output logic                      wr_stb,
    output logic [clogb2(NREG)-1:0]   wr_idx
);

    localparam int                NBYTES   = DWIDTH / 8;
    localparam int                ADDR_LSB = clogb2(NBYTES);
    localparam int                IDXW     = clogb2(NREG);
    localparam logic [DWIDTH-1:0] WINDOW   = DWIDTH'(NREG * NBYTES);

    logic                aw_full_r, w_full_r, bvalid_r, rvalid_r, wr_stb_r;
    logic [DWIDTH-1:0]   aw_addr_r, w_data_r;
    logic [NBYTES-1:0]   w_strb_r;
    logic [1:0]          bresp_r, rresp_r;
    logic [IDXW-1:0]     wr_idx_r;

    logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic                wr_in_range_s, rd_in_range_s;
    logic [DWIDTH-1:0]   wr_off_s, rd_off_s;
    logic [IDXW-1:0]     wr_reg_s, rd_reg_s;
    logic                unused_prot_s;

    assign unused_prot_s = ^{awprot, arprot};

    assign awready  = !aw_full_r && !bvalid_r;
    assign wready   = !w_full_r && !bvalid_r;
    assign arready  = !rvalid_r;
    assign aw_hs_s  = awvalid && awready;
    assign w_hs_s   = wvalid && wready;
    assign ar_hs_s  = arvalid && arready;
    assign commit_s = aw_full_r && w_full_r;

    // Offsets wrap in DWIDTH bits, so addresses below BASE land far out of the window.
    assign wr_off_s      = aw_addr_r - BASE;
    assign rd_off_s      = araddr - BASE;
    assign wr_in_range_s = wr_off_s < WINDOW;
    assign rd_in_range_s = rd_off_s < WINDOW;
    assign wr_reg_s      = wr_off_s[ADDR_LSB +: IDXW];
    assign rd_reg_s      = rd_off_s[ADDR_LSB +: IDXW];

    // AW and W holding slots; both empty together on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            aw_addr_r <= {DWIDTH{1'b0}};
            w_data_r  <= {DWIDTH{1'b0}};
            w_strb_r  <= {NBYTES{1'b0}};
        end else if (commit_s) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_full_r <= 1'b1;
                aw_addr_r <= awaddr;
            end
            if (w_hs_s) begin
                w_full_r <= 1'b1;
                w_data_r <= wdata;
                w_strb_r <= wstrb;
            end
        end
    end

    // Write response and commit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_r <= 1'b0;
            bresp_r  <= 2'b00;
            wr_stb_r <= 1'b0;
            wr_idx_r <= {IDXW{1'b0}};
        end else begin
            wr_stb_r <= commit_s && wr_in_range_s;
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
                wr_idx_r <= wr_reg_s;
            end else if (bvalid_r && bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read response; rdata itself is held by the register file's read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rresp_r  <= 2'b00;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rready) begin
            rvalid_r <= 1'b0;
        end
    end

    axi_lite_regfile #(
        .DWIDTH (DWIDTH),
        .NREG   (NREG),
        .IDXW   (IDXW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (commit_s && wr_in_range_s),
        .wr_idx  (wr_reg_s),
        .wr_data (w_data_r),
        .wr_strb (w_strb_r),
        .rd_en   (ar_hs_s),
        .rd_idx  (rd_reg_s),
        .rd_zero (!rd_in_range_s),
        .rd_data (rdata),
        .regs    (regs)
    );

    assign bvalid = bvalid_r;
    assign bresp  = bresp_r;
    assign rvalid = rvalid_r;
    assign rresp  = rresp_r;
    assign wr_stb = wr_stb_r;
    assign wr_idx = wr_idx_r;

endmodule
